// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared definitions for the multi-read-port register bank slice:
//   - default geometry constants (DATA_W / ADDR_W / NUM_RD)
//   - clear-engine state encoding (legacy-compatible constants + enum view)
//   - rd_slice(): base bit offset of one port inside a flattened port vector
// No ports (package).
// -----------------------------------------------------------------------------
package regbank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    // Raw state codes kept as plain constants so older code that compares
    // against bit patterns keeps working; the enum below reuses them.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR
    } clr_state_t;

    // Port p of a flattened vector whose fields are 'width' bits wide starts
    // at bit p*width.
    function automatic int rd_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regbank_mp_if.sv
// -----------------------------------------------------------------------------
// regbank_mp_if
// Bus bundle between the datapath (master) and the register bank (slave).
// Signals:
//   clr_req  master->slave  pulse, start a full clear sweep
//   clr_busy slave->master  clear sweep in progress
//   wEn/wAddr/wData         write port, master->slave
//   wReady   slave->master  write accepted this cycle
//   rEn/rAddr               per-port read request, flattened, master->slave
//   rData/rValid            per-port registered read result, slave->master
// -----------------------------------------------------------------------------
interface regbank_mp_if
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);

    logic                       clr_req;
    logic                       clr_busy;
    logic                       wEn;
    logic [ADDR_W-1:0]          wAddr;
    logic [DATA_W-1:0]          wData;
    logic                       wReady;
    logic [NUM_RD-1:0]          rEn;
    logic [NUM_RD*ADDR_W-1:0]   rAddr;
    logic [NUM_RD*DATA_W-1:0]   rData;
    logic [NUM_RD-1:0]          rValid;

    modport master (
        output clr_req, wEn, wAddr, wData, rEn, rAddr,
        input  clr_busy, wReady, rData, rValid
    );

    modport slave (
        input  clr_req, wEn, wAddr, wData, rEn, rAddr,
        output clr_busy, wReady, rData, rValid
    );

endinterface

// File: rtl/regbank_clear_fsm.sv
// -----------------------------------------------------------------------------
// regbank_clear_fsm
// Clear engine for the register bank. After reset (or on clr_req while idle)
// it walks every entry once, one per cycle, asking the top level to write 0.
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   synchronous active-low reset; (re)starts the sweep at entry 0
//   clr_req   in   start a sweep (ignored while a sweep is running)
//   clr_busy  out  high while the sweep runs
//   clr_we    out  clear write strobe for this cycle
//   clr_addr  out  entry being cleared this cycle
// -----------------------------------------------------------------------------
module regbank_clear_fsm
    import regbank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // The counter is one bit wider than an address so it can run past the
    // last entry without aliasing back onto entry 0.
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    clr_state_t      state_q, state_d;
    logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
    logic            clr_busy_q, clr_busy_d;

    // Next-state logic: idle waits for a request; clear steps one entry per
    // cycle and returns to idle after the last entry has been written.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        clr_busy_d = (state_d == CLEAR);
    end

    // Reset drops straight into a fresh sweep so storage never needs its own
    // reset network.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regbank_mp.sv
// -----------------------------------------------------------------------------
// regbank_mp
// Parametrised register bank with NUM_RD registered read ports, one write
// port with write-first bypass, and a built-in clear engine.
// Ports:
//   CLK      in     rising-edge clock
//   reset_n  in     synchronous active-low reset (read outputs to 0, sweep restarts)
//   bus      slave  regbank_mp_if: clear request/busy, write port, read ports
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), NUM_RD (1..4).
// Build option: define ZERO_REG_EN to hardwire entry 0 to zero (writes to it
// are discarded, reads of it return 0 and never see the bypass).
// -----------------------------------------------------------------------------
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic       CLK,
    input  logic       reset_n,
    regbank_mp_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [NUM_RD*DATA_W-1:0] rdata_flat;
    logic [NUM_RD-1:0]        rvalid_flat;

    regbank_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (CLK),
        .reset_n  (reset_n),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A user write only lands while the bank is idle; during a sweep it is
    // simply dropped.
    assign user_we      = bus.wEn & ~clr_busy;
    assign bus.clr_busy = clr_busy;
    assign bus.wReady   = ~clr_busy;

    // Single physical write port shared between the clear engine and the
    // user. Writes are held off during reset so a reset edge never disturbs
    // storage beyond what the sweep will clear anyway.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr;
        mem_wdata = '0;
        if (clr_we) begin
            mem_we = reset_n;
        end else if (user_we && !(ZERO_REG && (bus.wAddr == '0))) begin
            mem_we    = reset_n;
            mem_waddr = bus.wAddr;
            mem_wdata = bus.wData;
        end
    end

    // Storage has no reset; the clear sweep is what puts it in a known state.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rdata_q, rdata_d;
        logic              rvalid_q, rvalid_d;

        assign raddr = bus.rAddr[rd_slice(p, ADDR_W) +: ADDR_W];

        // Read result selection. Priority: sweep in progress reads as zero,
        // then the hardwired zero entry, then the same-edge write (write-first
        // bypass), then storage. With no request the old data is held.
        always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = bus.rEn[p];
            if (bus.rEn[p]) begin
                if (clr_busy) begin
                    rdata_d = '0;
                end else if (ZERO_REG && (raddr == '0)) begin
                    rdata_d = '0;
                end else if (user_we && (bus.wAddr == raddr)) begin
                    rdata_d = bus.wData;
                end else begin
                    rdata_d = mem_q[raddr];
                end
            end
        end

        // Registered read outputs, cleared by reset.
        always_ff @(posedge CLK) begin
            if (!reset_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata_flat[rd_slice(p, DATA_W) +: DATA_W] = rdata_q;
        assign rvalid_flat[p]                            = rvalid_q;
    end

    assign bus.rData  = rdata_flat;
    assign bus.rValid = rvalid_flat;

endmodule

// File: tb/tb_regbank_mp.sv
// -----------------------------------------------------------------------------
// tb_regbank_mp
// Randomised, scoreboarded bench for regbank_mp (32-bit data, 32 entries,
// 2 read ports). The driver keeps a plain array model of the bank plus a
// "sweep cycles remaining" counter and queues the expected read results and
// busy flag per cycle; an independent monitor compares on every falling edge.
// Honours ZERO_REG_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regbank_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 2 ** AW;

`ifdef ZERO_REG_EN
    localparam bit ZREG = 1'b1;
`else
    localparam bit ZREG = 1'b0;
`endif

    typedef struct {
        int          tag;
        int          port;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        int tag;
        bit busy;
    } busy_exp_t;

    logic CLK = 1'b0;
    logic reset_n;
    int   cycle = 0;
    int   checks = 0;
    int   passes = 0;

    rd_exp_t     rdQ[$];
    busy_exp_t   busyQ[$];
    logic [31:0] modelMem [DEPTH];
    int          clearLeft = 0;

    regbank_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regbank_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Edge counter used to tag when each expected result must appear.
    always @(posedge CLK) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        else
            passes++;
    endtask

    // Drive one cycle of inputs, predict what the next edge produces from the
    // bank's rules, then advance to just after that edge.
    task automatic applyStimulus(input bit rstN, input bit clr, input bit wen,
                                 input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic [1:0] ren, input logic [9:0] raddr);
        logic [4:0]  a;
        logic [31:0] d;
        reset_n     = rstN;
        bus.clr_req = clr;
        bus.wEn     = wen;
        bus.wAddr   = waddr;
        bus.wData   = wdata;
        bus.rEn     = ren;
        bus.rAddr   = raddr;
        if (!rstN) begin
            clearLeft = DEPTH;
        end else if (clearLeft > 0) begin
            for (int p = 0; p < NR; p++)
                if (ren[p]) rdQ.push_back('{cycle + 1, p, 32'h0});
            modelMem[DEPTH - clearLeft] = 32'h0;
            clearLeft--;
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (ren[p]) begin
                    a = raddr[p*AW +: AW];
                    if (ZREG && a == 5'd0)            d = 32'h0;
                    else if (wen && waddr == a)       d = wdata;
                    else                              d = modelMem[a];
                    rdQ.push_back('{cycle + 1, p, d});
                end
            end
            if (wen && !(ZREG && waddr == 5'd0)) modelMem[waddr] = wdata;
            if (clr) clearLeft = DEPTH;
        end
        busyQ.push_back('{cycle + 1, clearLeft > 0});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 5'd0, 32'h0, 2'b00, 10'd0);
    endtask

    task automatic readAll();
        logic [4:0] lo, hi;
        for (int a = 0; a < DEPTH / 2; a++) begin
            lo = 5'(a);
            hi = 5'(a + DEPTH / 2);
            applyStimulus(1, 0, 0, 5'd0, 32'h0, 2'b11, {hi, lo});
        end
    endtask

    // Monitor: on every falling edge, retire the expectations due this cycle
    // and flag any output that appears without one or expectations left behind.
    always @(negedge CLK) begin
        busy_exp_t be;
        rd_exp_t   re;
        while (busyQ.size() > 0 && busyQ[0].tag < cycle) begin
            be = busyQ.pop_front();
            checkOutput("busy_stale_tag", 64'(be.tag), 64'(cycle));
        end
        if (busyQ.size() > 0 && busyQ[0].tag == cycle) begin
            be = busyQ.pop_front();
            checkOutput("clr_busy", 64'(bus.clr_busy), 64'(be.busy));
            checkOutput("wReady", 64'(bus.wReady), 64'(!be.busy));
        end
        while (rdQ.size() > 0 && rdQ[0].tag < cycle) begin
            re = rdQ.pop_front();
            checkOutput("read_missed_tag", 64'(re.tag), 64'(cycle));
        end
        for (int p = 0; p < NR; p++) begin
            if (rdQ.size() > 0 && rdQ[0].tag == cycle && rdQ[0].port == p) begin
                re = rdQ.pop_front();
                checkOutput($sformatf("rValid%0d", p), 64'(bus.rValid[p]), 64'd1);
                checkOutput($sformatf("rData%0d", p), 64'(bus.rData[p*DW +: DW]), 64'(re.data));
            end else if (bus.rValid[p] === 1'b1) begin
                checkOutput($sformatf("rValid%0d_unexpected", p), 64'd1, 64'd0);
            end
        end
    end

    // Directed scenarios followed by a randomised phase.
    initial begin
        logic [4:0]  wa;
        logic [4:0]  ra0, ra1;
        logic [1:0]  ren;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;

        // Reset held two cycles, then the post-reset sweep with reads in flight.
        applyStimulus(0, 0, 0, 5'd0, 32'h0, 2'b11, 10'd0);
        applyStimulus(0, 0, 0, 5'd0, 32'h0, 2'b11, 10'd0);
        checkOutput("reset_rData", 64'(bus.rData), 64'd0);
        checkOutput("reset_rValid", 64'(bus.rValid), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, 0, 1, 5'($urandom), $urandom, 2'b11, 10'($urandom));
        readAll();

        // Plain write then read, and same-edge bypass on port 1.
        applyStimulus(1, 0, 1, 5'd5, 32'hDEADBEEF, 2'b00, 10'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 2'b01, {5'd0, 5'd5});
        applyStimulus(1, 0, 1, 5'd7, 32'h00001234, 2'b10, {5'd7, 5'd0});
        idle(1);

        // Fill, clear with a dropped mid-sweep write, then read everything.
        for (int i = 1; i < DEPTH; i++)
            applyStimulus(1, 0, 1, 5'(i), 32'hA5A50000 + i, 2'b00, 10'd0);
        applyStimulus(1, 1, 0, 5'd0, 32'h0, 2'b00, 10'd0);
        idle(9);
        applyStimulus(1, 1, 1, 5'd3, 32'hCAFEF00D, 2'b00, 10'd0);
        idle(DEPTH);
        readAll();

        // Reset in the middle of a sweep restarts it from entry 0.
        applyStimulus(1, 1, 0, 5'd0, 32'h0, 2'b00, 10'd0);
        idle(9);
        applyStimulus(0, 0, 0, 5'd0, 32'h0, 2'b00, 10'd0);
        idle(DEPTH + 2);

        // Entry 0 with same-edge read, then a later read.
        applyStimulus(1, 0, 1, 5'd0, 32'hFFFFFFFF, 2'b11, 10'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 2'b11, 10'd0);

        // Random traffic, biased towards bypass hits, rare clears and resets.
        for (int i = 0; i < 600; i++) begin
            wa  = 5'($urandom);
            ra0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom);
            ren = 2'($urandom);
            applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 79) == 0),
                          1'($urandom), wa, $urandom, ren, {ra1, ra0});
        end
        idle(DEPTH + 1);
        readAll();
        idle(2);

        @(negedge CLK);
        #1;
        checkOutput("read_queue_drained", 64'(rdQ.size()), 64'd0);
        checkOutput("busy_queue_drained", 64'(busyQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
